// File: rtl/video_sync_gen.sv
// Raster timing stage: reloads the external horizontal counter chain, keeps the vertical line count
// and produces registered sync/blank outputs. Define FLIP_SCREEN_EN for a per-frame flipped v_cnt output.
module video_sync_gen #(
    parameter logic [8:0] H_START      = 9'h080,
    parameter logic [8:0] HBLANK_END   = 9'h090,
    parameter logic [8:0] HBLANK_START = 9'h190,
    parameter logic [8:0] HSYNC_START  = 9'h1B0,
    parameter logic [8:0] HSYNC_END    = 9'h1D0,
    parameter logic [8:0] V_START      = 9'h0F8,
    parameter logic [8:0] VBLANK_END   = 9'h110,
    parameter logic [8:0] VBLANK_START = 9'h1F0,
    parameter logic [8:0] VSYNC_START  = 9'h1F8,
    parameter logic [8:0] VSYNC_END    = 9'h1FC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic [8:0] h_cnt,
    input  logic       h_ca,
`ifdef FLIP_SCREEN_EN
    input  logic       flip,
`endif
    output logic       h_load_n,
    output logic [8:0] h_load_val,
    output logic       hsync,
    output logic       hblank,
    output logic [8:0] v_cnt,
    output logic       vsync,
    output logic       vblank,
    output logic       frame_start
);

    logic [8:0] v_int;
    logic [8:0] v_next;
    logic       line_end;
    logic       frame_wrap;

    // The chain reloads on the same edge it would otherwise roll over from 511.
    assign h_load_n   = ~(h_ca & pix_ce & ~reset);
    assign h_load_val = H_START;

    // Line advance trusts the count decode rather than the carry input.
    assign line_end   = pix_ce & (h_cnt == 9'h1FF);
    assign frame_wrap = (v_int == 9'h1FF);
    assign v_next     = frame_wrap ? V_START : v_int + 9'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            v_int       <= V_START;
            hsync       <= 1'b0;
            hblank      <= 1'b1;
            vsync       <= 1'b0;
            vblank      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_ce) begin
                hblank <= ~((h_cnt >= HBLANK_END) && (h_cnt < HBLANK_START));
                hsync  <= (h_cnt >= HSYNC_START) && (h_cnt < HSYNC_END);
            end
            // Vertical decode uses the upcoming count so v_cnt, vblank and vsync move together.
            if (line_end) begin
                v_int       <= v_next;
                vblank      <= ~((v_next >= VBLANK_END) && (v_next < VBLANK_START));
                vsync       <= (v_next >= VSYNC_START) && (v_next < VSYNC_END);
                frame_start <= frame_wrap;
            end
        end
    end

`ifdef FLIP_SCREEN_EN
    logic flip_q;

    // Flip is captured only at the frame boundary so a frame is never split between orientations.
    always_ff @(posedge clk) begin
        if (reset) begin
            flip_q <= 1'b0;
        end else if (line_end && frame_wrap) begin
            flip_q <= flip;
        end
    end

    assign v_cnt = flip_q ? (v_int ^ 9'h0FF) : v_int;
`else
    assign v_cnt = v_int;
`endif

endmodule

// File: tb/tb_video_sync_gen.sv
// Directed self-checking bench for video_sync_gen; models the external counter chain and,
// with FLIP_SCREEN_EN defined, exercises the flip feature as well.
module tb_video_sync_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_ce;
    logic [8:0] h_cnt;
    logic       h_ca;
    logic       h_load_n;
    logic [8:0] h_load_val;
    logic       hsync;
    logic       hblank;
    logic [8:0] v_cnt;
    logic       vsync;
    logic       vblank;
    logic       frame_start;
`ifdef FLIP_SCREEN_EN
    logic       flip = 1'b0;
`endif

    int   n_checks = 0;
    int   n_fail = 0;
    logic chain_on = 1'b0;

    always #5 clk = ~clk;

    assign h_ca = pix_ce && (h_cnt == 9'h1FF);

    video_sync_gen dut (
        .clk(clk),
        .reset(reset),
        .pix_ce(pix_ce),
        .h_cnt(h_cnt),
        .h_ca(h_ca),
`ifdef FLIP_SCREEN_EN
        .flip(flip),
`endif
        .h_load_n(h_load_n),
        .h_load_val(h_load_val),
        .hsync(hsync),
        .hblank(hblank),
        .v_cnt(v_cnt),
        .vsync(vsync),
        .vblank(vblank),
        .frame_start(frame_start)
    );

    // One clock; when chain_on the bench plays the role of the cascaded counter chain.
    task automatic tick();
        logic ld;
        logic ce;
        ld = h_load_n;
        ce = pix_ce;
        @(posedge clk);
        #1;
        if (chain_on && ce) h_cnt = ld ? h_cnt + 9'd1 : h_load_val;
        #1;
    endtask

    task automatic run_to(input logic [8:0] target);
        int n;
        n = 0;
        while (h_cnt !== target && n < 1000) begin
            tick();
            n++;
        end
        if (h_cnt !== target) begin $display("[TB] FAIL run_to timeout: h_cnt %h, wanted %h", h_cnt, target); n_fail++; end
        n_checks++;
    endtask

    // Expected vertical count k lines after reset (264-line frame starting at 0x0F8).
    function automatic logic [8:0] line_val(input int k);
        return 9'(32'h0F8 + (k % 264));
    endfunction

    task automatic test_reset();
        reset = 1'b1; pix_ce = 1'b1; chain_on = 1'b0; h_cnt = 9'h1FF;
        #1;
        if (h_load_n !== 1'b1) begin $display("[TB] FAIL reset_load_n: got %b, expected 1", h_load_n); n_fail++; end
        n_checks++;
        tick();
        tick();
        if (v_cnt !== 9'h0F8) begin $display("[TB] FAIL reset_v_cnt: got %h, expected 0f8", v_cnt); n_fail++; end
        n_checks++;
        if (hsync !== 1'b0) begin $display("[TB] FAIL reset_hsync: got %b, expected 0", hsync); n_fail++; end
        n_checks++;
        if (hblank !== 1'b1) begin $display("[TB] FAIL reset_hblank: got %b, expected 1", hblank); n_fail++; end
        n_checks++;
        if (vsync !== 1'b0) begin $display("[TB] FAIL reset_vsync: got %b, expected 0", vsync); n_fail++; end
        n_checks++;
        if (vblank !== 1'b1) begin $display("[TB] FAIL reset_vblank: got %b, expected 1", vblank); n_fail++; end
        n_checks++;
        if (frame_start !== 1'b0) begin $display("[TB] FAIL reset_frame_start: got %b, expected 0", frame_start); n_fail++; end
        n_checks++;
        if (h_load_val !== 9'h080) begin $display("[TB] FAIL h_load_val: got %h, expected 080", h_load_val); n_fail++; end
        n_checks++;
    endtask

    task automatic test_chain_reload();
        int n;
        int glitch;
        reset = 1'b0; h_cnt = 9'h000; chain_on = 1'b1;
        #1;
        tick();
        n = 1;
        if (hblank !== 1'b1) begin $display("[TB] FAIL out_of_range_blank: got %b, expected 1", hblank); n_fail++; end
        n_checks++;
        while (h_cnt !== 9'h1FF && n < 600) begin
            tick();
            n++;
        end
        if (n !== 511) begin $display("[TB] FAIL first_line_len: got %0d, expected 511", n); n_fail++; end
        n_checks++;
        if (h_load_n !== 1'b0) begin $display("[TB] FAIL load_at_511: got %b, expected 0", h_load_n); n_fail++; end
        n_checks++;
        tick();
        n = 1;
        glitch = 0;
        if (h_cnt !== 9'h080) begin $display("[TB] FAIL reload_value: got %h, expected 080", h_cnt); n_fail++; end
        n_checks++;
        if (v_cnt !== 9'h0F9) begin $display("[TB] FAIL first_line_advance: got %h, expected 0f9", v_cnt); n_fail++; end
        n_checks++;
        while (h_cnt !== 9'h1FF && n < 1000) begin
            tick();
            n++;
            if ((h_cnt === 9'h1FF) === (h_load_n === 1'b1)) glitch++;
        end
        if (n !== 384) begin $display("[TB] FAIL line_period: got %0d, expected 384", n); n_fail++; end
        n_checks++;
        if (glitch !== 0) begin $display("[TB] FAIL load_n_timing: got %0d bad clocks, expected 0", glitch); n_fail++; end
        n_checks++;
    endtask

    task automatic test_hdecode();
        int hs_len;
        run_to(9'h08F);
        tick();
        if (hblank !== 1'b1) begin $display("[TB] FAIL hblank_before_active: got %b, expected 1", hblank); n_fail++; end
        n_checks++;
        tick();
        if (hblank !== 1'b0) begin $display("[TB] FAIL hblank_fall: got %b, expected 0", hblank); n_fail++; end
        n_checks++;
        run_to(9'h190);
        if (hblank !== 1'b0) begin $display("[TB] FAIL hblank_last_active: got %b, expected 0", hblank); n_fail++; end
        n_checks++;
        tick();
        if (hblank !== 1'b1) begin $display("[TB] FAIL hblank_rise: got %b, expected 1", hblank); n_fail++; end
        n_checks++;
        run_to(9'h1B0);
        if (hsync !== 1'b0) begin $display("[TB] FAIL hsync_before: got %b, expected 0", hsync); n_fail++; end
        n_checks++;
        tick();
        if (hsync !== 1'b1) begin $display("[TB] FAIL hsync_rise: got %b, expected 1", hsync); n_fail++; end
        n_checks++;
        hs_len = 0;
        while (hsync === 1'b1 && hs_len < 100) begin
            hs_len++;
            tick();
        end
        if (hs_len !== 32) begin $display("[TB] FAIL hsync_width: got %0d, expected 32", hs_len); n_fail++; end
        n_checks++;
    endtask

    task automatic test_reset_midline();
        run_to(9'h1C0);
        if (hsync !== 1'b1) begin $display("[TB] FAIL midline_hsync_pre: got %b, expected 1", hsync); n_fail++; end
        n_checks++;
        reset = 1'b1;
        tick();
        if (hsync !== 1'b0 || hblank !== 1'b1) begin $display("[TB] FAIL midline_reset_h: got hs=%b hb=%b, expected hs=0 hb=1", hsync, hblank); n_fail++; end
        n_checks++;
        if (v_cnt !== 9'h0F8 || vblank !== 1'b1 || vsync !== 1'b0) begin $display("[TB] FAIL midline_reset_v: got v=%h vb=%b vs=%b, expected v=0f8 vb=1 vs=0", v_cnt, vblank, vsync); n_fail++; end
        n_checks++;
        reset = 1'b0;
        tick();
        if (hsync !== 1'b1 || hblank !== 1'b1) begin $display("[TB] FAIL midline_restart: got hs=%b hb=%b, expected hs=1 hb=1", hsync, hblank); n_fail++; end
        n_checks++;
    endtask

    task automatic test_frame();
        int vb_low, vs_hi, fs, fs_at;
        logic [8:0] vb_first, vs_first;
        chain_on = 1'b0; pix_ce = 1'b1; reset = 1'b1; h_cnt = 9'h100;
        tick();
        reset = 1'b0;
        vb_low = 0; vs_hi = 0; fs = 0; fs_at = -1; vb_first = 9'h000; vs_first = 9'h000;
        for (int k = 1; k <= 264; k++) begin
            h_cnt = 9'h1FF;
            tick();
            if (v_cnt !== line_val(k)) begin $display("[TB] FAIL frame_v_cnt line %0d: got %h, expected %h", k, v_cnt, line_val(k)); n_fail++; end
            n_checks++;
            if (vblank === 1'b0) begin
                if (vb_low == 0) vb_first = v_cnt;
                vb_low++;
            end
            if (vsync === 1'b1) begin
                if (vs_hi == 0) vs_first = v_cnt;
                vs_hi++;
            end
            if (frame_start === 1'b1) begin fs++; fs_at = k; end
            h_cnt = 9'h100;
            tick();
            if (frame_start === 1'b1) fs++;
        end
        if (vb_low !== 224 || vb_first !== 9'h110) begin $display("[TB] FAIL vblank_window: got %0d lines from %h, expected 224 from 110", vb_low, vb_first); n_fail++; end
        n_checks++;
        if (vs_hi !== 4 || vs_first !== 9'h1F8) begin $display("[TB] FAIL vsync_window: got %0d lines from %h, expected 4 from 1f8", vs_hi, vs_first); n_fail++; end
        n_checks++;
        if (fs !== 1 || fs_at !== 264) begin $display("[TB] FAIL frame_start_pulse: got %0d pulses at line %0d, expected 1 at 264", fs, fs_at); n_fail++; end
        n_checks++;
    endtask

    task automatic test_pix_ce_toggle();
        int fs, hold_bad, load_bad;
        chain_on = 1'b0;
        pix_ce = 1'b1; h_cnt = 9'h08F;
        tick();
        pix_ce = 1'b0; h_cnt = 9'h090;
        tick();
        if (hblank !== 1'b1) begin $display("[TB] FAIL ce_hold_hblank: got %b, expected 1", hblank); n_fail++; end
        n_checks++;
        pix_ce = 1'b1;
        tick();
        if (hblank !== 1'b0) begin $display("[TB] FAIL ce_resume_hblank: got %b, expected 0", hblank); n_fail++; end
        n_checks++;
        reset = 1'b1; h_cnt = 9'h100;
        tick();
        reset = 1'b0;
        fs = 0; hold_bad = 0; load_bad = 0;
        for (int k = 1; k <= 264; k++) begin
            pix_ce = 1'b1; h_cnt = 9'h1FF;
            tick();
            if (frame_start === 1'b1) fs++;
            pix_ce = 1'b0;
            #1;
            if (h_load_n !== 1'b1) load_bad++;
            tick();
            if (frame_start === 1'b1) fs++;
            if (v_cnt !== line_val(k)) hold_bad++;
            pix_ce = 1'b1; h_cnt = 9'h100;
            tick();
            if (frame_start === 1'b1) fs++;
            pix_ce = 1'b0;
            tick();
            if (frame_start === 1'b1) fs++;
        end
        if (fs !== 1) begin $display("[TB] FAIL ce_frame_start_width: got %0d clocks, expected 1", fs); n_fail++; end
        n_checks++;
        if (hold_bad !== 0) begin $display("[TB] FAIL ce_v_cnt_hold: got %0d bad lines, expected 0", hold_bad); n_fail++; end
        n_checks++;
        if (load_bad !== 0) begin $display("[TB] FAIL ce_load_n_idle: got %0d bad clocks, expected 0", load_bad); n_fail++; end
        n_checks++;
        if (v_cnt !== 9'h0F8) begin $display("[TB] FAIL ce_frame_wrap: got %h, expected 0f8", v_cnt); n_fail++; end
        n_checks++;
        pix_ce = 1'b1;
    endtask

`ifdef FLIP_SCREEN_EN
    task automatic advance_lines(input int count);
        for (int i = 0; i < count; i++) begin
            h_cnt = 9'h1FF;
            tick();
            h_cnt = 9'h100;
            tick();
        end
    endtask

    task automatic test_flip();
        chain_on = 1'b0; pix_ce = 1'b1; flip = 1'b0; reset = 1'b1; h_cnt = 9'h100;
        tick();
        reset = 1'b0;
        advance_lines(20);
        flip = 1'b1;
        advance_lines(1);
        if (v_cnt !== 9'h10D) begin $display("[TB] FAIL flip_not_latched: got %h, expected 10d", v_cnt); n_fail++; end
        n_checks++;
        advance_lines(235);
        if (v_cnt !== 9'h1F8 || vsync !== 1'b1) begin $display("[TB] FAIL flip_pre_frame: got v=%h vs=%b, expected v=1f8 vs=1", v_cnt, vsync); n_fail++; end
        n_checks++;
        advance_lines(8);
        if (v_cnt !== 9'h007) begin $display("[TB] FAIL flip_wrap: got %h, expected 007", v_cnt); n_fail++; end
        n_checks++;
        flip = 1'b0;
        advance_lines(256);
        if (v_cnt !== 9'h107 || vsync !== 1'b1 || vblank !== 1'b1) begin $display("[TB] FAIL flip_decode: got v=%h vs=%b vb=%b, expected v=107 vs=1 vb=1", v_cnt, vsync, vblank); n_fail++; end
        n_checks++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (v_cnt !== 9'h0F8 || vblank !== 1'b1) begin $display("[TB] FAIL flip_reset: got v=%h vb=%b, expected v=0f8 vb=1", v_cnt, vblank); n_fail++; end
        n_checks++;
        advance_lines(1);
        if (v_cnt !== 9'h0F9) begin $display("[TB] FAIL flip_cleared: got %h, expected 0f9", v_cnt); n_fail++; end
        n_checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_chain_reload();
        test_hdecode();
        test_reset_midline();
        test_frame();
        test_pix_ce_toggle();
`ifdef FLIP_SCREEN_EN
        test_flip();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
